// File: rtl/imm_field_encoder.sv
// imm_field_encoder: range-checks a 64-bit immediate against an ARMv8 template's format and packs it.
// Build option IMMENC_ALIGN_CHECK_EN: flag CB/B byte offsets with imm[1:0]!=0 instead of truncating them.
module imm_field_encoder #(
  parameter int ERRCNT_W = 16
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [63:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [2:0]          out_class,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_D    = 3'd1,
    CLS_CB   = 3'd2,
    CLS_B    = 3'd3,
    CLS_RSH  = 3'd4,
    CLS_RIMM = 3'd5
  } cls_e;

  logic                s1_valid_q;
  logic [31:0]         s1_instr_q;
  logic [27:0]         s1_imm_q;
  cls_e                s1_class_q;
  logic                s1_err_q;

  logic                out_valid_q;
  logic [31:0]         out_instr_q;
  cls_e                out_class_q;
  logic                out_err_q;
  logic [ERRCNT_W-1:0] err_count_q;
  logic [ERRCNT_W-1:0] err_count_d;

  cls_e                class_d;
  logic                range_ok;
  logic                align_bad;
  logic                err_d;
  logic [31:0]         pack_d;
  logic                s1_advance;
  logic                in_fire;

  // Stage 1: class decode, first match wins.
  always_comb begin
    class_d = CLS_NONE;
    casez (in_instr[31:21])
      11'b111110000?0: class_d = CLS_D;
      11'b10110100???: class_d = CLS_CB;
      11'b000101?????: class_d = CLS_B;
      11'b1101001101?: class_d = CLS_RSH;
      11'b1?01000100?: class_d = CLS_RIMM;
      default:         class_d = CLS_NONE;
    endcase
  end

`ifdef IMMENC_ALIGN_CHECK_EN
  assign align_bad = ((class_d == CLS_CB) || (class_d == CLS_B)) && (in_imm[1:0] != 2'b00);
`else
  assign align_bad = 1'b0;
`endif

  // Signed fields need the upper bits to be a pure sign extension; unsigned need them all zero.
  always_comb begin
    range_ok = 1'b0;
    case (class_d)
      CLS_D:    range_ok = (&in_imm[63:8])  || !(|in_imm[63:8]);
      CLS_CB:   range_ok = (&in_imm[63:20]) || !(|in_imm[63:20]);
      CLS_B:    range_ok = (&in_imm[63:27]) || !(|in_imm[63:27]);
      CLS_RSH:  range_ok = !(|in_imm[63:6]);
      CLS_RIMM: range_ok = !(|in_imm[63:12]);
      default:  range_ok = 1'b0;
    endcase
    err_d = !range_ok || align_bad;
  end

  // Stage 2: field insertion; an error zeroes the field, an unknown class passes the template through.
  always_comb begin
    pack_d = s1_instr_q;
    case (s1_class_q)
      CLS_D:    pack_d[20:12] = s1_err_q ? 9'd0  : s1_imm_q[8:0];
      CLS_CB:   pack_d[23:5]  = s1_err_q ? 19'd0 : s1_imm_q[20:2];
      CLS_B:    pack_d[25:0]  = s1_err_q ? 26'd0 : s1_imm_q[27:2];
      CLS_RSH:  pack_d[15:10] = s1_err_q ? 6'd0  : s1_imm_q[5:0];
      CLS_RIMM: pack_d[21:10] = s1_err_q ? 12'd0 : s1_imm_q[11:0];
      default:  pack_d = s1_instr_q;
    endcase
  end

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && out_err_q && !(&err_count_q)) begin
      err_count_d = err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= 32'd0;
      s1_imm_q    <= 28'd0;
      s1_class_q  <= CLS_NONE;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_class_q <= CLS_NONE;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_instr_q <= in_instr;
        s1_imm_q   <= in_imm[27:0];
        s1_class_q <= class_d;
        s1_err_q   <= err_d;
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_advance) begin
        out_valid_q <= 1'b1;
        out_instr_q <= pack_d;
        out_class_q <= s1_class_q;
        out_err_q   <= s1_err_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule
